// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing stream evaluator.
package sc_pkg;

  typedef enum logic [1:0] {
    SC_AND = 2'd0,
    SC_MUX = 2'd1,
    SC_OR  = 2'd2,
    SC_XOR = 2'd3
  } sc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sc_state_e;

  // Rotate the low 'width' bits of value left by 'amount'; width must be below 32.
  function automatic logic [31:0] rotl(input logic [31:0] value, input int width,
                                       input int amount);
    int n;
    logic [31:0] mask;
    n    = amount % width;
    mask = (32'h1 << width) - 32'h1;
    return ((value << n) | (value >> (width - n))) & mask;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR shifting right, feedback into the MSB; a zero load value is replaced by SEED.
module sc_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hCF,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state
);

  logic fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == '0) ? SEED : load_value;
    end else if (enable) begin
      state <= {fb, state[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sc_stream_evaluator.sv
// Stochastic-computing evaluator: NUM_CH operands become LFSR-compared bit streams,
// are combined by a selectable SC operator, and the 1s are counted back to binary.
module sc_stream_evaluator
  import sc_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hCF,
  parameter logic [WIDTH-1:0] SEED   = 8'h01,
  parameter int               LEN    = 255,
  parameter int               NUM_CH = 2,
  parameter int               ROT    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0]        seed,
  output logic                    busy,
  output logic                    sc_bit,
  output logic [WIDTH-1:0]        result,
  output logic                    result_valid,
  input  logic                    result_ready
);

  localparam logic [WIDTH-1:0] LAST_CYCLE = WIDTH'(LEN - 1);

  sc_state_e               state;
  sc_mode_e                mode_lat;
  logic [NUM_CH*WIDTH-1:0] b_lat;
  logic [WIDTH-1:0]        ones;
  logic [WIDTH-1:0]        cycle;
  logic [WIDTH-1:0]        lfsr_state;
  logic [NUM_CH-1:0]       ch_bits;
  logic                    comb_bit;
  logic                    accept;
  logic [WIDTH-1:0]        ones_next;

  assign accept    = (state == ST_IDLE) && start;
  assign ones_next = ones + {{(WIDTH-1){1'b0}}, comb_bit};

  sc_lfsr #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .enable    (state == ST_RUN),
    .load_value(seed),
    .state     (lfsr_state)
  );

  // Each channel sees its own rotated view of the shared LFSR to decorrelate the streams.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WIDTH-1:0] view;
    assign view       = WIDTH'(rotl(32'(lfsr_state), WIDTH, k * ROT));
    assign ch_bits[k] = view < b_lat[k*WIDTH +: WIDTH];
  end

  always_comb begin
    comb_bit = 1'b0;
    unique case (mode_lat)
      SC_AND:  comb_bit = &ch_bits;
      SC_OR:   comb_bit = |ch_bits;
      SC_XOR:  comb_bit = ^ch_bits;
      SC_MUX:  comb_bit = lfsr_state[0] ? ch_bits[1] : ch_bits[0];
      default: comb_bit = 1'b0;
    endcase
  end

  // result_valid rises one cycle after entering DONE, so the handshake only completes once it is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mode_lat     <= SC_AND;
      b_lat        <= '0;
      ones         <= '0;
      cycle        <= '0;
      busy         <= 1'b0;
      sc_bit       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_lat <= sc_mode_e'(mode);
            b_lat    <= in_b;
            ones     <= '0;
            cycle    <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sc_bit <= comb_bit;
          ones   <= ones_next;
          cycle  <= cycle + 1'b1;
          if (cycle == LAST_CYCLE) begin
            result <= ones_next;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          sc_bit       <= 1'b0;
          result_valid <= 1'b1;
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_evaluator.sv
// Randomised self-checking bench for sc_stream_evaluator, with a ROT=0 twin instance.
module tb_sc_stream_evaluator;

  localparam int WIDTH  = 8;
  localparam int LEN    = 255;
  localparam int NUM_CH = 2;
  localparam int ROT    = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    result_ready = 1'b0;
  logic [1:0]              mode = '0;
  logic [NUM_CH*WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0]        seed = '0;

  logic             busy, sc_bit, result_valid;
  logic [WIDTH-1:0] result;
  logic             busy_z, sc_bit_z, result_valid_z;
  logic [WIDTH-1:0] result_z;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sc_stream_evaluator #(.ROT(ROT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_b(in_b), .seed(seed),
    .busy(busy), .sc_bit(sc_bit), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  sc_stream_evaluator #(.ROT(0)) dut_rot0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_b(in_b), .seed(seed),
    .busy(busy_z), .sc_bit(sc_bit_z), .result(result_z), .result_valid(result_valid_z),
    .result_ready(result_ready)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Walks the whole stream from the rules: LFSR sequence, rotated comparisons, operator, count.
  function automatic int modelCount(input int md, input int b0, input int b1, input int sd,
                                    input int rot);
    int s, v1, cnt, x0, x1, y;
    s   = (sd == 0) ? 1 : sd;
    cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      v1 = ((s << rot) | (s >> (WIDTH - rot))) & 255;
      x0 = (s < b0) ? 1 : 0;
      x1 = (v1 < b1) ? 1 : 0;
      case (md)
        0:       y = x0 & x1;
        1:       y = (s % 2 == 1) ? x1 : x0;
        2:       y = x0 | x1;
        default: y = x0 ^ x1;
      endcase
      cnt += y;
      s = (s >> 1) | (($countones(s & 'hCF) % 2) << 7);
    end
    return cnt;
  endfunction

  // Launches one evaluation, scrambles the inputs afterwards, waits for the result and checks it.
  task automatic applyStimulus(input int md, input int b0, input int b1, input int sd,
                               output int expected);
    int latency;
    int exp_z;
    expected = modelCount(md, b0, b1, sd, ROT);
    exp_z    = modelCount(md, b0, b1, sd, 0);
    @(negedge clk);
    mode  = md[1:0];
    in_b  = {b1[7:0], b0[7:0]};
    seed  = sd[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", int'(busy), 1);
    mode  = 2'($urandom);
    in_b  = 16'($urandom);
    seed  = 8'($urandom);
    latency = 0;
    while (!result_valid && latency < 400) begin
      @(negedge clk);
      latency++;
    end
    checkOutput("latency", latency, LEN + 1);
    checkOutput("result", int'(result), expected);
    checkOutput("result_valid_rot0", int'(result_valid_z), 1);
    checkOutput("result_rot0", int'(result_z), exp_z);
  endtask

  // Holds the result for 'hold' cycles, pokes start along the way, then releases it.
  task automatic releaseResult(input int expected, input int hold);
    for (int i = 0; i < hold; i++) begin
      start = (i == hold / 2);
      @(negedge clk);
      checkOutput("hold_valid", int'(result_valid), 1);
      checkOutput("hold_result", int'(result), expected);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start        = 1'b0;
    checkOutput("valid_dropped", int'(result_valid), 0);
    checkOutput("busy_after_release", int'(busy), 0);
    checkOutput("result_kept_idle", int'(result), expected);
    @(negedge clk);
    checkOutput("exit_start_ignored", int'(busy), 0);
  endtask

  initial begin
    int expv;
    int md, b0, b1, sd;

    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_sc_bit", int'(sc_bit), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_valid", int'(result_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2, 0, 100, 1, expv);
    checkOutput("or_0_100", int'(result), 99);
    releaseResult(expv, 0);

    applyStimulus(0, 128, 255, 1, expv);
    checkOutput("and_128_255", int'(result), 127);
    releaseResult(expv, 0);

    applyStimulus(0, 0, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), expv);
    checkOutput("and_zero", int'(result), 0);
    releaseResult(expv, 0);

    applyStimulus(3, 200, 200, 1, expv);
    checkOutput("xor_rot0_equal", int'(result_z), 0);
    releaseResult(expv, 0);

    applyStimulus(2, 0, 50, 0, expv);
    checkOutput("seed_zero", int'(result), 49);
    releaseResult(expv, 0);
    applyStimulus(2, 0, 50, 1, expv);
    checkOutput("seed_default", int'(result), 49);
    releaseResult(expv, 0);

    applyStimulus(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), expv);
    releaseResult(expv, 20);
    applyStimulus(2, 0, 30, 1, expv);
    checkOutput("start_after_hold", int'(result), 29);
    releaseResult(expv, 0);

    for (int n = 0; n < 6; n++) begin
      md = int'($urandom_range(0, 3));
      b0 = int'($urandom_range(0, 255));
      b1 = int'($urandom_range(0, 255));
      sd = int'($urandom_range(0, 255));
      applyStimulus(md, b0, b1, sd, expv);
      releaseResult(expv, int'($urandom_range(0, 3)));
    end

    // Abort mid-run after a nonzero result is sitting in the output register.
    applyStimulus(2, 0, 100, 7, expv);
    releaseResult(expv, 0);
    @(negedge clk);
    mode  = 2'd2;
    in_b  = {8'd100, 8'd0};
    seed  = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(result_valid), 0);
    checkOutput("abort_result", int'(result), 0);
    checkOutput("abort_sc_bit", int'(sc_bit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 0, 100, 1, expv);
    checkOutput("after_abort", int'(result), 99);
    releaseResult(expv, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sc_stream_evaluator.md
Name: sc_stream_evaluator

Overview:
Parametrised stochastic-computing evaluator and the next generation of the single-LFSR/comparator SC cell. It runs a Fibonacci LFSR through a configurable stream length and converts NUM_CH binary operands into stochastic bits, each through its own comparator against a rotated LFSR view. The channel bits are combined with a run-time selectable SC operator, and the 1s in the output stream are counted back to binary. Result is returned on a valid/ready handshake; the block sits between the binary operand source and the downstream accumulator.

Parameters:
WIDTH, 8, LFSR, operand and result width
TAPS, 8'hCF, feedback mask; fb = XOR of state bits where mask=1 (default bits 7,6,3,2,1,0)
SEED, 8'h01, LFSR reset value and substitute for a zero seed
LEN, 255, stream length in cycles; must be ≤ 2^WIDTH-1
NUM_CH, 2, number of operand channels (≥2)
ROT, 3, per-channel rotation step; channel k compares against LFSR rotated left by k*ROT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new evaluation; accepted only in IDLE
mode  in  2  operator: 0 AND, 1 MUX (scaled add), 2 OR, 3 XOR; latched at accept
in_b  in  NUM_CH*WIDTH  operands, channel k at [k*WIDTH +: WIDTH]; latched at accept
seed  in  WIDTH  LFSR start value, latched at accept
busy  out  1  high in RUN and DONE
sc_bit  out  1  registered combined stochastic bit of the current RUN cycle
result  out  WIDTH  count of 1s in the stream
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset (async assert, sync release): state IDLE, LFSR=SEED, counters 0, busy=0, sc_bit=0, result=0, result_valid=0.
- LFSR step: next = {fb, s[WIDTH-1:1]}, fb = ^(s & TAPS). It shifts only in RUN.
- Comparator k: bit_k = (rotl(s, k*ROT) < b_k), unsigned compare.
- Operators:
  - AND: all bit_k.
  - OR: any bit_k.
  - XOR: parity of bit_k.
  - MUX: bit_0 when s[0]=0, else bit_1; other channels are ignored.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: start=1 latches mode, in_b and seed, loads the LFSR with the seed (SEED if seed==0), clears ones/cycle counters, and goes to RUN.
  - RUN: each cycle evaluates the operator on the current s, registers sc_bit, adds the bit to the ones counter, steps the LFSR and increments the cycle counter. After the LEN-th cycle the FSM goes to DONE and result takes the final count.
  - DONE: result_valid=1 and result is held stable. result_ready=1 returns to IDLE with result_valid dropping the next cycle. result keeps its last value in IDLE.
- Latency: start accepted at edge T; RUN cycles T+1..T+LEN; result_valid is high from edge T+LEN+1.
- start in RUN/DONE is ignored, with no queueing. start on the same cycle that DONE exits is also ignored.
- Input changes during RUN have no effect; the latched copies are used.
- The ones counter is WIDTH bits and cannot overflow because LEN ≤ 2^WIDTH-1.
- Reset mid-RUN or mid-DONE aborts immediately; the result is lost and all outputs return to reset values.
- Over a full period (LEN=2^WIDTH-1, primitive TAPS) every nonzero state appears once, so a single channel with operand b yields b-1 ones for b≥1 and 0 for b=0.

Decomposition:
- Package sc_pkg: the mode encoding enum (SC_AND, SC_MUX, SC_OR, SC_XOR), the FSM state enum, and a rotl function.
- One natural sub-module: sc_lfsr (WIDTH, TAPS, SEED) with load/enable/state ports.
- The comparators and operator stay inline.

Test Plan:
1. OR, in_b ch0=0, ch1=100, default params -> result=99, result_valid at 256 cycles after accept.
2. AND, ch0=128, ch1=255 -> result=127 (ch1 is 0 only at s=255, where ch0 is already 0).
3. AND, ch0=0, any ch1 -> result=0. XOR with ch0=ch1=200 and ROT=0 -> result=0.
4. seed=0 with OR, ch0=0, ch1=50 -> same count as seed=SEED (49); the LFSR never sticks at 0.
5. Hold result_ready=0 for 20 cycles in DONE:
   - result_valid and result stay stable and a start pulse is ignored;
   - on ready the FSM returns to IDLE;
   - a following start is accepted.
6. Assert rst_n low at RUN cycle 100 -> busy, result_valid, result and sc_bit are 0 immediately. After release, a fresh run gives the full expected count.
